// File: rtl/instr_encoder_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : instr_encoder_loader_pkg
//  Description : Shared definitions for the RV32I instruction encoder/loader:
//                format tags, base opcodes, immediate range limits and the
//                loader state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package instr_encoder_loader_pkg;

    // Format tags carried on the fmt input; 6 and 7 are not legal formats.
    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    // RV32I base opcodes.
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_REG    = 7'h33;

    // Representable immediate ranges (B and J are byte offsets, must be even).
    localparam int IMM12_MIN = -2048;
    localparam int IMM12_MAX = 2047;
    localparam int IMMB_MIN  = -4096;
    localparam int IMMB_MAX  = 4094;
    localparam int IMMJ_MIN  = -(1 << 20);
    localparam int IMMJ_MAX  = (1 << 20) - 2;

    // Loader control states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Signed inclusive range test on a full 32-bit immediate.
    function automatic logic imm_in_range(input logic [31:0] v, input int lo, input int hi);
        return ($signed(v) >= lo) && ($signed(v) <= hi);
    endfunction

endpackage : instr_encoder_loader_pkg
`default_nettype wire

// File: rtl/instr_encoder_loader_encode.sv
`default_nettype none
// ============================================================================
//  Module      : instr_encode
//  Description : Pure combinational RV32I assembler. Packs instruction fields
//                into a 32-bit word according to the format tag and flags
//                immediates that the format cannot represent.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_encode
    import instr_encoder_loader_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  f3,
    input  logic [6:0]  f7,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    // Field packing and legality per format; unknown tags are illegal.
    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (fmt)
            FMT_R: begin
                word = {f7, rs2, rs1, f3, rd, opcode};
            end
            FMT_I: begin
                word    = {imm[11:0], rs1, f3, rd, opcode};
                illegal = !imm_in_range(imm, IMM12_MIN, IMM12_MAX);
            end
            FMT_S: begin
                word    = {imm[11:5], rs2, rs1, f3, imm[4:0], opcode};
                illegal = !imm_in_range(imm, IMM12_MIN, IMM12_MAX);
            end
            FMT_B: begin
                word    = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opcode};
                illegal = !imm_in_range(imm, IMMB_MIN, IMMB_MAX) || imm[0];
            end
            FMT_U: begin
                // The low 12 bits are not encodable, so a nonzero value there
                // would be silently lost.
                word    = {imm[31:12], rd, opcode};
                illegal = (imm[11:0] != 12'd0);
            end
            FMT_J: begin
                word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                illegal = !imm_in_range(imm, IMMJ_MIN, IMMJ_MAX) || imm[0];
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule : instr_encode
`default_nettype wire

// File: rtl/instr_encoder_loader.sv
`default_nettype none
// ============================================================================
//  Module      : instr_encoder_loader
//  Description : Accepts instruction field tuples, encodes them to RV32I words
//                and writes them sequentially into instruction memory through
//                a one-entry buffer that honours memory backpressure. Illegal
//                tuples are consumed and flagged on a sticky error bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder_loader
    import instr_encoder_loader_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0,
    parameter int DEPTH     = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        f3,
    input  logic [6:0]        f7,
    input  logic [31:0]       imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              imem_ready,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err,
    output logic              done
);

    localparam logic [ADDR_W-1:0] c_base  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   c_depth = (ADDR_W + 1)'(DEPTH);

    state_t              r_state;
    logic                r_done;
    logic                r_err;
    logic                r_buf_valid;
    logic [31:0]         r_wdata;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W:0]     r_count;

    logic [31:0]         w_word;
    logic                w_illegal;
    logic [ADDR_W:0]     w_loaded;
    logic                w_room;
    logic                w_write;
    logic                w_accept;

    instr_encode u_encode (
        .fmt     (fmt),
        .opcode  (opcode),
        .rd      (rd),
        .rs1     (rs1),
        .rs2     (rs2),
        .f3      (f3),
        .f7      (f7),
        .imm     (imm),
        .word    (w_word),
        .illegal (w_illegal)
    );

    // Words committed to the load so far: written ones plus the buffered one.
    // A write only moves a word from the buffer to memory, so it does not
    // change this total; an accept is allowed while the total is below DEPTH.
    assign w_loaded = r_count + (ADDR_W + 1)'(r_buf_valid);
    assign w_room   = (w_loaded < c_depth);
    assign w_write  = r_buf_valid && imem_ready;

    // The buffer can take a new word when empty or when it empties this
    // cycle, which gives one word per clock under no backpressure.
    assign in_ready = (r_state == ST_LOAD) && w_room && (!r_buf_valid || w_write);
    assign w_accept = in_valid && in_ready;

    assign imem_we    = r_buf_valid;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign count      = r_count;
    assign full       = (w_loaded == c_depth);
    assign err        = r_err;
    assign done       = r_done;

    // Control FSM: start from any state wins over finish; FLUSH waits for the
    // buffer to drain before declaring DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
        end else if (start) begin
            r_state <= ST_LOAD;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (finish) begin
                        r_state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (!r_buf_valid || w_write) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= r_state;
                end
            endcase
        end
    end

    // Output buffer, write address, word count and sticky error. A start
    // discards the buffered word (and any tuple handshaked in that cycle),
    // so the next load begins cleanly at the base address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf_valid <= 1'b0;
            r_wdata     <= '0;
            r_addr      <= c_base;
            r_count     <= '0;
            r_err       <= 1'b0;
        end else if (start) begin
            r_buf_valid <= 1'b0;
            r_addr      <= c_base;
            r_count     <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_write) begin
                r_addr  <= r_addr + ADDR_W'(1);
                r_count <= r_count + (ADDR_W + 1)'(1);
            end

            if (w_accept && !w_illegal) begin
                r_buf_valid <= 1'b1;
                r_wdata     <= w_word;
            end else if (w_write) begin
                r_buf_valid <= 1'b0;
            end

            if (w_accept && w_illegal) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule : instr_encoder_loader
`default_nettype wire

// File: tb/tb_instr_encoder_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_encoder_loader
//  Description : Scoreboard bench for instr_encoder_loader. The driver queues
//                the hand-computed word and address of every legal tuple it
//                hands over; a monitor pops and compares on each memory write.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_encoder_loader;
    import instr_encoder_loader_pkg::*;

    localparam int ADDR_W    = 4;
    localparam int BASE_ADDR = 14;
    localparam int DEPTH     = 4;
    localparam logic [ADDR_W-1:0] c_base = ADDR_W'(BASE_ADDR);

    logic              clk;
    logic              rst;
    logic              start;
    logic              finish;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        fmt;
    logic [6:0]        opcode;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [2:0]        f3;
    logic [6:0]        f7;
    logic [31:0]       imm;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              imem_ready;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              err;
    logic              done;

    instr_encoder_loader #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE_ADDR),
        .DEPTH     (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .finish     (finish),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .fmt        (fmt),
        .opcode     (opcode),
        .rd         (rd),
        .rs1        (rs1),
        .rs2        (rs2),
        .f3         (f3),
        .f7         (f7),
        .imm        (imm),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .imem_ready (imem_ready),
        .count      (count),
        .full       (full),
        .err        (err),
        .done       (done)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } exp_t;

    exp_t              sb[$];
    exp_t              e;
    logic [ADDR_W-1:0] exp_addr;
    int                checks;
    int                errors;
    int                cyc;
    int                cyc_r;
    int                cyc_s;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Drive one tuple and hold it until handshaked (bounded); legal tuples
    // queue their expected address/word for the monitor.
    task automatic send(input logic [2:0] t_fmt, input logic [6:0] t_op, input logic [4:0] t_rd,
                        input logic [4:0] t_rs1, input logic [4:0] t_rs2, input logic [2:0] t_f3,
                        input logic [6:0] t_f7, input logic [31:0] t_imm,
                        input logic [31:0] t_exp, input logic t_legal);
        int n;
        fmt = t_fmt; opcode = t_op; rd = t_rd; rs1 = t_rs1; rs2 = t_rs2;
        f3 = t_f3; f7 = t_f7; imm = t_imm;
        in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 20) begin
                checks++;
                errors++;
                $display("FAIL handshake_timeout: in_ready 0 for %0d cycles, required 1", n);
                in_valid = 1'b0;
                return;
            end
        end
        if (t_legal) begin
            sb.push_back('{addr: exp_addr, data: t_exp});
            exp_addr = exp_addr + ADDR_W'(1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        sb.delete();
        exp_addr = c_base;
    endtask

    task automatic pulse_finish();
        finish = 1'b1;
        @(posedge clk);
        #1;
        finish = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("done_reached", done, 1);
    endtask

    // Monitor: every accepted memory write must match the head of the queue.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && imem_we && imem_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %0h data %08h, required no write", imem_addr, imem_wdata);
                end else begin
                    e = sb.pop_front();
                    check("wr_addr", 64'(imem_addr), 64'(e.addr));
                    check("wr_data", 64'(imem_wdata), 64'(e.data));
                    if (imem_wdata == 32'h002081B3) cyc_r = cyc;
                    if (imem_wdata == 32'h0020A423) cyc_s = cyc;
                end
            end
        end
    end

    initial begin
        checks = 0; errors = 0; cyc = 0; cyc_r = -1; cyc_s = -100;
        exp_addr = c_base;
        rst = 1'b1; start = 1'b0; finish = 1'b0; in_valid = 1'b0; imem_ready = 1'b1;
        fmt = '0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0; f3 = '0; f7 = '0; imm = '0;

        // Reset state.
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_we", imem_we, 0);
        check("rst_addr", imem_addr, c_base);
        check("rst_wdata", imem_wdata, 0);
        check("rst_count", count, 0);
        check("rst_flags", {full, err, done}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Load 1: I, R+S back-to-back, B fills DEPTH; addresses wrap 14,15,0,1.
        pulse_start();
        send(FMT_I, OP_IMM,    5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5,  32'h00500093, 1'b1);
        send(FMT_R, OP_REG,    5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0,  32'h002081B3, 1'b1);
        send(FMT_S, OP_STORE,  5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8,  32'h0020A423, 1'b1);
        send(FMT_B, OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd4, 32'hFE208EE3, 1'b1);
        check("full_after_4th", full, 1);
        check("ready_when_full", in_ready, 0);
        // A fifth tuple must stall, not be dropped or written.
        fmt = FMT_U; opcode = OP_LUI; rd = 5'd5; imm = 32'h12345000; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_5th_ready", in_ready, 0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("count_full", count, 4);
        check("rs_consecutive", 64'(cyc_s - cyc_r), 1);
        pulse_finish();
        wait_done();

        // Load 2: U, illegal tuples, J, then memory backpressure.
        pulse_start();
        check("restart_clear", {done, err, imem_we}, 0);
        check("restart_count", count, 0);
        check("restart_addr", imem_addr, c_base);
        send(FMT_U, OP_LUI,    5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123452B7, 1'b1);
        send(FMT_I, OP_IMM,    5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096,     32'h0, 1'b0);
        send(FMT_B, OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3,        32'h0, 1'b0);
        send(3'd7,  OP_IMM,    5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0,        32'h0, 1'b0);
        send(FMT_U, OP_LUI,    5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001, 32'h0, 1'b0);
        check("illegal_err", err, 1);
        check("illegal_count", count, 1);
        check("illegal_no_we", imem_we, 0);
        send(FMT_J, OP_JAL,    5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,     32'h001000EF, 1'b1);
        imem_ready = 1'b0;
        fork
            send(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd2048, 32'h80000093, 1'b1);
            begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("bp_we", imem_we, 1);
                    check("bp_addr", imem_addr, 4'd15);
                    check("bp_wdata", imem_wdata, 32'h001000EF);
                    check("bp_ready", in_ready, 0);
                end
                @(posedge clk);
                #1;
                imem_ready = 1'b1;
            end
        join
        send(FMT_S, OP_STORE, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd2047, 32'h7E20AFA3, 1'b1);
        check("err_sticky", err, 1);
        pulse_finish();
        wait_done();
        check("load2_count", count, 4);
        check("load2_full", full, 1);

        // Start during FLUSH with a word stuck in the buffer.
        pulse_start();
        imem_ready = 1'b0;
        send(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093, 1'b1);
        pulse_finish();
        @(posedge clk);
        #1;
        check("flush_blocked", {done, imem_we}, 2'b01);
        pulse_start();
        check("flush_restart_we", imem_we, 0);
        check("flush_restart_addr", imem_addr, c_base);
        check("flush_restart_count", count, 0);
        check("flush_restart_ready", in_ready, 1);

        // Asynchronous reset with a word buffered.
        send(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093, 1'b1);
        check("pre_rst_we", imem_we, 1);
        #2;
        rst = 1'b1;
        #1;
        sb.delete();
        check("arst_we", imem_we, 0);
        check("arst_addr", imem_addr, c_base);
        check("arst_wdata", imem_wdata, 0);
        check("arst_count", count, 0);
        check("arst_flags", {in_ready, full, err, done}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        imem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_idle", {imem_we, in_ready}, 0);
        check("sb_empty", 64'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_instr_encoder_loader
`default_nettype wire
